loading_bar_reader: RTL and testbench

LOADING_BAR_READER -- requirements
Module: loading_bar_reader

---
 rtl/loading_bar_reader.sv | 145 ++++++++++++++
 tb/tb_loading_bar_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/loading_bar_reader.sv
// Polls a progress percentage from on-chip memory, converts it to a 10-segment bar and
// writes the segment count back. Optional leading-segment blink: LOADING_BAR_BLINK_EN.
module loading_bar_reader #(
  parameter int unsigned POLL_CYCLES = 50000,
  parameter logic [9:0]  PROG_ADDR   = 10'h000,
  parameter int unsigned NUM_LEDS    = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [9:0]          mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [3:0]          mem_byteenable,
  output logic [31:0]         mem_writedata,
  output logic                mem_clken,
  input  logic [31:0]         mem_readdata,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy
);

  localparam logic [31:0] PollLast = 32'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdCap,
    StDiv,
    StWb,
    StUpdate
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  prog_q, prog_d;   // progress, reduced in place to the remainder during DIV
  logic [3:0]  quot_q, quot_d;
  logic [9:0]  leds_q, leds_d;
  logic        clken_q;
  logic [10:0] therm;

`ifdef LOADING_BAR_BLINK_EN
  logic blink_q, blink_d;
`endif

  // Only the low byte of the progress word is meaningful.
  logic unused_rdata;
  assign unused_rdata = ^mem_readdata[31:8];

  assign therm = (11'd1 << quot_q) - 11'd1;

  always_comb begin
    state_d        = state_q;
    poll_cnt_d     = poll_cnt_q;
    prog_d         = prog_q;
    quot_d         = quot_q;
    leds_d         = leds_q;
`ifdef LOADING_BAR_BLINK_EN
    blink_d        = blink_q;
`endif
    mem_address    = 10'h000;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 4'b0000;
    mem_writedata  = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (poll_cnt_q == PollLast) begin
          poll_cnt_d = 32'h0;
          state_d    = StRdReq;
`ifdef LOADING_BAR_BLINK_EN
          blink_d    = ~blink_q;
`endif
        end else begin
          poll_cnt_d = poll_cnt_q + 32'd1;
        end
      end
      StRdReq: begin
        mem_address    = PROG_ADDR;
        mem_chipselect = 1'b1;
        state_d        = StRdCap;
      end
      StRdCap: begin
        prog_d  = (mem_readdata[7:0] > 8'd100) ? 8'd100 : mem_readdata[7:0];
        quot_d  = 4'd0;
        state_d = StDiv;
      end
      StDiv: begin
        if (prog_q < 8'd10) begin
          state_d = StWb;
        end else begin
          prog_d = prog_q - 8'd10;
          quot_d = quot_q + 4'd1;
        end
      end
      StWb: begin
        mem_address    = PROG_ADDR + 10'd1;  // wraps within the 10-bit word space
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = 4'b0001;
        mem_writedata  = {24'h0, 4'h0, quot_q};
        state_d        = StUpdate;
      end
      StUpdate: begin
        leds_d = therm[9:0];
`ifdef LOADING_BAR_BLINK_EN
        if (quot_q < 4'd10) begin
          leds_d[quot_q] = blink_q;
        end
`endif
        poll_cnt_d = 32'h0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      poll_cnt_q <= 32'h0;
      prog_q     <= 8'h0;
      quot_q     <= 4'h0;
      leds_q     <= 10'h0;
      clken_q    <= 1'b0;
`ifdef LOADING_BAR_BLINK_EN
      blink_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      prog_q     <= prog_d;
      quot_q     <= quot_d;
      leds_q     <= leds_d;
      clken_q    <= 1'b1;
`ifdef LOADING_BAR_BLINK_EN
      blink_q    <= blink_d;
`endif
    end
  end

  assign mem_clken = clken_q;
  assign leds      = leds_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_loading_bar_reader.sv
// Directed bench for loading_bar_reader: two instances (progress word at 0 and at 3FF)
// against small behavioural memory models.
module tb_loading_bar_reader;

  localparam int unsigned PollCycles = 16;
  localparam logic [31:0] ProgWordB  = 32'd37;

  logic        clk;
  logic        reset_n;

  logic [9:0]  a_addr, b_addr;
  logic        a_cs, a_we, a_clken, a_busy, b_cs, b_we, b_clken, b_busy;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic [9:0]  a_leds, b_leds;

  logic [31:0] prog_word_a = 32'h0;
  logic [31:0] status_a = 32'h0, status_b = 32'h0;
  int          wr_cnt_a = 0, wr_cnt_b = 0;
  logic [9:0]  rd_addr_a = 10'h0, rd_addr_b = 10'h0;
  logic [9:0]  last_wr_addr_a = 10'h0, last_wr_addr_b = 10'h0;
  logic [31:0] last_wr_data_a = 32'h0;
  logic [3:0]  last_be_a = 4'h0;

  int          total = 0;
  int          bad = 0;
  logic        blink_m = 1'b0;

  loading_bar_reader #(
    .POLL_CYCLES (PollCycles),
    .PROG_ADDR   (10'h000),
    .NUM_LEDS    (10)
  ) u_dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_address    (a_addr),
    .mem_chipselect (a_cs),
    .mem_write      (a_we),
    .mem_byteenable (a_be),
    .mem_writedata  (a_wdata),
    .mem_clken      (a_clken),
    .mem_readdata   (a_rdata),
    .leds           (a_leds),
    .busy           (a_busy)
  );

  loading_bar_reader #(
    .POLL_CYCLES (PollCycles),
    .PROG_ADDR   (10'h3FF),
    .NUM_LEDS    (10)
  ) u_dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_address    (b_addr),
    .mem_chipselect (b_cs),
    .mem_write      (b_we),
    .mem_byteenable (b_be),
    .mem_writedata  (b_wdata),
    .mem_clken      (b_clken),
    .mem_readdata   (b_rdata),
    .leds           (b_leds),
    .busy           (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model A: progress word at 0, status at 1.
  always @(posedge clk) begin
    if (a_clken && a_cs) begin
      if (!a_we) begin
        a_rdata   <= (a_addr == 10'h000) ? prog_word_a : 32'h0;
        rd_addr_a <= a_addr;
      end else begin
        wr_cnt_a       <= wr_cnt_a + 1;
        last_wr_addr_a <= a_addr;
        last_wr_data_a <= a_wdata;
        last_be_a      <= a_be;
        if (a_addr == 10'h001) begin
          for (int i = 0; i < 4; i++) begin
            if (a_be[i]) status_a[8*i +: 8] <= a_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Memory model B: progress word at 3FF, status wraps to 0.
  always @(posedge clk) begin
    if (b_clken && b_cs) begin
      if (!b_we) begin
        b_rdata   <= (b_addr == 10'h3FF) ? ProgWordB : 32'h0;
        rd_addr_b <= b_addr;
      end else begin
        wr_cnt_b       <= wr_cnt_b + 1;
        last_wr_addr_b <= b_addr;
        if (b_addr == 10'h000) begin
          for (int i = 0; i < 4; i++) begin
            if (b_be[i]) status_b[8*i +: 8] <= b_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] exp_leds(input int q);
    logic [10:0] t;
    logic [9:0]  r;
    t = (11'd1 << q) - 11'd1;
    r = t[9:0];
`ifdef LOADING_BAR_BLINK_EN
    if (q < 10) r[q] = blink_m;
`endif
    return r;
  endfunction

  // Negedges until RD_REQ is seen on port A; -1 if it never comes.
  task automatic wait_read(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (a_cs && !a_we) begin
        cyc = n;
        blink_m = ~blink_m;
        break;
      end
    end
  endtask

  // Negedges from RD_REQ until busy drops; -1 if it never does.
  task automatic wait_done(output int k);
    k = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (!a_busy) begin
        k = n;
        break;
      end
    end
  endtask

  task automatic poll(input logic [31:0] word, input int q);
    int c, k, w0;
    prog_word_a = word;
    w0 = wr_cnt_a;
    wait_read(c);
    check("poll_period", c, PollCycles);
    check("rd_addr_out", {22'h0, a_addr}, 32'h0);
    wait_done(k);
    check("latency", k, 5 + q);
    check("leds", {22'h0, a_leds}, {22'h0, exp_leds(q)});
    check("write_count", wr_cnt_a - w0, 1);
    check("write_addr", {22'h0, last_wr_addr_a}, 32'h1);
    check("write_data", last_wr_data_a, q);
    check("write_be", {28'h0, last_be_a}, 32'h1);
    check("status_word", status_a, q);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_leds"}, {22'h0, a_leds}, 32'h0);
    check({tag, "_busy"}, {31'h0, a_busy}, 32'h0);
    check({tag, "_cs"}, {31'h0, a_cs}, 32'h0);
    check({tag, "_we"}, {31'h0, a_we}, 32'h0);
    check({tag, "_be"}, {28'h0, a_be}, 32'h0);
    check({tag, "_addr"}, {22'h0, a_addr}, 32'h0);
    check({tag, "_wdata"}, a_wdata, 32'h0);
    check({tag, "_clken"}, {31'h0, a_clken}, 32'h0);
  endtask

  initial begin
    int c, k, w0;
    reset_n = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("clken_release", {31'h0, a_clken}, 32'h1);

    poll(32'd37, 3);
    check("b_rd_addr", {22'h0, rd_addr_b}, 32'h3FF);
    check("b_wr_addr", {22'h0, last_wr_addr_b}, 32'h0);
    check("b_status", status_b, 32'h3);
    check("b_wr_count", wr_cnt_b, 1);

    poll(32'hFFFF_FF05, 0);
    poll(32'd45, 4);
    poll(32'd45, 4);
    poll(32'd100, 10);
    poll(32'd250, 10);

    // Abort in the middle of DIV: no write, timer restarts from zero.
    prog_word_a = 32'd90;
    w0 = wr_cnt_a;
    wait_read(c);
    check("pre_abort_period", c, PollCycles);
    repeat (4) @(negedge clk);
    check("in_div_busy", {31'h0, a_busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    blink_m = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_read(c);
    check("post_abort_period", c, PollCycles);
    check("abort_no_write", wr_cnt_a - w0, 0);
    wait_done(k);
    check("post_abort_latency", k, 14);
    check("post_abort_leds", {22'h0, a_leds}, {22'h0, exp_leds(9)});
    check("post_abort_status", status_a, 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
